lru_feeder: RTL
===============

Name: lru_feeder

Overview:
Transmit-side companion to the 4-entry LRU byte buffer. Accepts bytes from an upstream producer into a small circular FIFO. Presents them one at a time to the LRU buffer as a one-cycle valid_data pulse, holding data stable for the buffer's whole multi-cycle hit-check/update sequence. Paces issues using a minimum-gap counter plus the buffer's reported state, because the buffer itself has no ready signal.

Parameters:
DATA_W, 8, width of each byte/entry sent to the LRU buffer
DEPTH, 8, FIFO entries; must be a power of 2, minimum 2
GAP, 12, minimum cycles between consecutive valid_data pulses; covers the buffer's worst case of 1 idle + 5 check + 5 update cycles, plus 1 margin cycle
CNT_W, 16, width of issued_count

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  upstream byte present
in_data  in  DATA_W  upstream byte
in_ready  out  1  FIFO can accept; equals (fifo_count < DEPTH), combinational
lru_state  in  2  buffer state_debug; 0 = IDLE
valid_data  out  1  one-cycle issue pulse to the buffer
data  out  DATA_W  byte to the buffer; held stable between issues
fifo_count  out  log2(DEPTH)+1  current FIFO occupancy
issued_count  out  CNT_W  bytes issued since reset; wraps modulo 2^CNT_W
drop  out  1  sticky; set when in_valid && !in_ready

Behaviour:
- Reset (async, any state): valid_data=0, data=0, fifo_count=0, rd/wr pointers=0, issued_count=0, drop=0, gap counter=0, FSM=IDLE. Reset mid-hold abandons the held byte and any FIFO contents.
- FIFO:
  - Push on in_valid && in_ready. Write at wr_ptr, wr_ptr wraps DEPTH-1 -> 0.
  - Pop only on issue (see FSM).
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Push while full: data ignored, drop<=1 (sticky until reset).
- FSM states: IDLE, WAIT.
  - IDLE: issue when fifo_count>0 && lru_state==0. On the issue edge:
    - valid_data<=1, data<=mem[rd_ptr]; rd_ptr++ (wraps); count--; issued_count++.
    - gap<=GAP-1; next state WAIT.
  - WAIT: valid_data<=0 on the first WAIT edge (pulse is exactly 1 cycle). gap decrements each cycle while nonzero. When gap==0 && lru_state==0, go to IDLE.
- Issue spacing:
  - Rising edges of valid_data are at least GAP+1 cycles apart (1 IDLE evaluation cycle + GAP-1 WAIT decrements + the exit cycle).
  - Further delayed while lru_state!=0.
- Latency: a byte pushed into an empty FIFO while in IDLE with lru_state==0 appears on valid_data/data at the next edge after the push edge (1-cycle latency).
- data holds its last issued value through WAIT and IDLE; it changes only at an issue edge.
- Empty FIFO in IDLE: remain in IDLE, valid_data=0.
- lru_state stuck nonzero: remain in WAIT/IDLE indefinitely; FIFO still accepts until full.
- GAP<2 is illegal; guard with an elaboration-time check.

Decomposition:
- Shared package lru_pkg:
  - LRU buffer state encodings (LRU_IDLE=0, LRU_CHECK=1, LRU_HIT_UPD=2, LRU_MISS_UPD=3).
  - Feeder FSM encodings (FEED_IDLE, FEED_WAIT).
  - Default DATA_W and GAP constants, shared with the buffer bench.
- One sub-module, lru_feeder_fifo: circular storage, pointers, count, in_ready and drop. The top level holds the FSM, gap counter and issue outputs.

Test Plan:
- Reset, then push 0xA5 with lru_state=0 -> valid_data high exactly 1 cycle on the next edge, data=0xA5 held, issued_count=1, fifo_count=0.
- Push 0x11, 0x22, 0x33 back-to-back, lru_state=0 -> three pulses with rising edges exactly GAP+1=13 cycles apart; data sequence 0x11, 0x22, 0x33.
- Hold lru_state=1 for 30 cycles after the first issue with 2 bytes queued -> no second pulse until lru_state returns to 0, then the next pulse follows within 1 cycle.
- Fill DEPTH=8 with lru_state=3, then push a 9th byte 0xFF -> in_ready=0, drop=1, 0xFF never issued. Release lru_state -> 8 bytes issued in order, pointers wrap, fifo_count returns to 0.
- With 4 bytes queued, assert rst mid-WAIT -> immediately valid_data=0, data=0, fifo_count=0, issued_count=0, drop=0; nothing issued after rst deasserts until a new push.
- Simultaneous push and issue with the FIFO at count 1 -> count stays 1, correct byte order preserved.

Source files
------------

// File: rtl/lru_pkg.sv
// lru_pkg
//   Shared definitions for the 4-entry LRU byte buffer and its transmit-side
//   feeder: buffer state_debug encodings, feeder FSM encodings and the default
//   byte width / issue gap used by both designs and their benches.
package lru_pkg;

    typedef enum logic [1:0] {
        LRU_IDLE     = 2'd0,
        LRU_CHECK    = 2'd1,
        LRU_HIT_UPD  = 2'd2,
        LRU_MISS_UPD = 2'd3
    } lru_state_e;

    typedef enum logic {
        FEED_IDLE = 1'b0,
        FEED_WAIT = 1'b1
    } feed_state_e;

    localparam int LRU_DATA_W = 8;
    // 1 idle + 5 check + 5 update cycles of the buffer, plus 1 margin cycle.
    localparam int LRU_GAP    = 12;

endpackage

// File: rtl/lru_feeder_fifo.sv
// lru_feeder_fifo
//   Circular byte FIFO in front of the LRU buffer feeder.
//   Ports:
//     clk, rst       clock / async active-high reset
//     in_valid       upstream byte present
//     in_data        upstream byte
//     in_ready       FIFO not full (combinational from count)
//     pop            consume the head entry (caller only pops when non-empty)
//     head_data      entry at the read pointer
//     count          current occupancy
//     drop           sticky: a byte was offered while full
module lru_feeder_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    input  logic                       pop,
    output logic [DATA_W-1:0]          head_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("lru_feeder_fifo: DEPTH must be a power of 2 and at least 2");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;

    assign in_ready  = (count < FULL);
    assign push      = in_valid && in_ready;
    assign head_data = mem[rd_ptr];

    // Storage is not reset; only entries behind the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            drop   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (in_valid && !in_ready) begin
                drop <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/lru_feeder.sv
// lru_feeder
//   Transmit-side companion to the LRU byte buffer. Queues upstream bytes and
//   issues them one at a time as a single-cycle valid_data pulse, holding data
//   stable until the next issue. The buffer has no ready, so issues are paced
//   by a minimum-gap down-counter and by the buffer's reported state.
//   Ports:
//     clk, rst       clock / async active-high reset
//     in_valid       upstream byte present
//     in_data        upstream byte
//     in_ready       FIFO can accept (fifo_count < DEPTH)
//     lru_state      buffer state_debug, 0 = idle
//     valid_data     one-cycle issue pulse to the buffer
//     data           issued byte, held between issues
//     fifo_count     FIFO occupancy
//     issued_count   bytes issued since reset (wraps)
//     drop           sticky overflow flag
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   FEED_IDLE | ready to issue once the FIFO is non-empty and buffer idle
//   FEED_WAIT | pulse done; counting down the gap, then waiting for idle
module lru_feeder
    import lru_pkg::*;
#(
    parameter int DATA_W = LRU_DATA_W,
    parameter int DEPTH  = 8,
    parameter int GAP    = LRU_GAP,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    input  logic [1:0]                 lru_state,
    output logic                       valid_data,
    output logic [DATA_W-1:0]          data,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [CNT_W-1:0]           issued_count,
    output logic                       drop
);

    localparam int GAP_W = (GAP < 2) ? 1 : $clog2(GAP);

    if (GAP < 2) begin : g_gap_chk
        $error("lru_feeder: GAP must be at least 2");
    end

    feed_state_e       state;
    logic [GAP_W-1:0]  gap;
    logic [DATA_W-1:0] head_data;
    logic              lru_idle;
    logic              issue;

    assign lru_idle = (lru_state == 2'(LRU_IDLE));
    assign issue    = (state == FEED_IDLE) && (fifo_count != '0) && lru_idle;

    lru_feeder_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .pop       (issue),
        .head_data (head_data),
        .count     (fifo_count),
        .drop      (drop)
    );

    // Issue edge loads GAP-1; GAP-1 WAIT decrements plus the exit cycle and
    // the next IDLE evaluation put successive pulses at least GAP+1 apart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= FEED_IDLE;
            gap          <= '0;
            valid_data   <= 1'b0;
            data         <= '0;
            issued_count <= '0;
        end else begin
            case (state)
                FEED_IDLE: begin
                    valid_data <= 1'b0;
                    if (issue) begin
                        valid_data   <= 1'b1;
                        data         <= head_data;
                        issued_count <= issued_count + CNT_W'(1);
                        gap          <= GAP_W'(GAP - 1);
                        state        <= FEED_WAIT;
                    end
                end
                FEED_WAIT: begin
                    valid_data <= 1'b0;
                    if (gap != '0) begin
                        gap <= gap - GAP_W'(1);
                    end else if (lru_idle) begin
                        state <= FEED_IDLE;
                    end
                end
                default: begin
                    valid_data <= 1'b0;
                    state      <= FEED_IDLE;
                end
            endcase
        end
    end

endmodule
